// File: rtl/bht_update_queue.sv
// rtl/bht_update_queue.sv - in-order queue of in-flight BHT predictions with registered counter update
// Define BHTQ_FWD_EN to forward a popped counter update into queued entries with the same index.
module bht_update_queue #(
    parameter int IDX_W = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_valid,
    input  logic [IDX_W-1:0]           pred_idx,
    input  logic [1:0]                 pred_cnt,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    input  logic                       flush,
    output logic                       upd_we,
    output logic [IDX_W-1:0]           upd_idx,
    output logic [1:0]                 upd_data,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [IDX_W-1:0] q_idx [DEPTH];
    logic [1:0]       q_cnt [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;
    logic [1:0]       head_cnt;
    logic [1:0]       head_next;
    logic [1:0]       push_cnt;

    // Two-bit saturating counter with hysteresis: 00 SNT, 01 WNT, 11 ST, 10 WT.
    function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        case (cnt)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b11 : 2'b00;
            2'b11:   nxt = taken ? 2'b11 : 2'b10;
            default: nxt = taken ? 2'b11 : 2'b00;
        endcase
        return nxt;
    endfunction

    always_comb begin
        full      = (occ == OCC_W'(DEPTH));
        empty     = (occ == '0);
        push      = pred_valid && !full && !flush;
        pop       = res_valid && !empty;
        head_idx  = q_idx[rd_ptr];
        head_cnt  = q_cnt[rd_ptr];
        head_next = next_cnt(head_cnt, res_taken);
`ifdef BHTQ_FWD_EN
        push_cnt  = (pop && (pred_idx == head_idx)) ? head_next : pred_cnt;
`else
        push_cnt  = pred_cnt;
`endif
    end

    assign pred_ready = !full;
    assign res_ready  = !empty;
    assign occupancy  = occ;

    // The push write comes last so it overrides any forwarding hit on the free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_idx[i] <= '0;
                q_cnt[i] <= '0;
            end
        end else begin
`ifdef BHTQ_FWD_EN
            if (pop) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_idx[i] == head_idx) begin
                        q_cnt[i] <= head_next;
                    end
                end
            end
`endif
            if (push) begin
                q_idx[wr_ptr] <= pred_idx;
                q_cnt[wr_ptr] <= push_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Index and data hold their last written value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_we     <= 1'b0;
            upd_idx    <= '0;
            upd_data   <= '0;
            mispredict <= 1'b0;
        end else begin
            upd_we     <= pop;
            mispredict <= pop && (head_cnt[1] ^ res_taken);
            if (pop) begin
                upd_idx  <= head_idx;
                upd_data <= head_next;
            end
        end
    end

endmodule

// File: tb/tb_bht_update_queue.sv
// tb/tb_bht_update_queue.sv - randomized self-checking bench with a queue-based reference model
// Build with BHTQ_FWD_EN defined to check the forwarding variant.
module tb_bht_update_queue;

    localparam int IDX_W = 10;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pred_valid = 1'b0;
    logic [IDX_W-1:0] pred_idx = '0;
    logic [1:0]       pred_cnt = '0;
    logic             pred_ready;
    logic             res_valid = 1'b0;
    logic             res_taken = 1'b0;
    logic             res_ready;
    logic             flush = 1'b0;
    logic             upd_we;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_data;
    logic             mispredict;
    logic [OCC_W-1:0] occupancy;

    bht_update_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_cnt(pred_cnt), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .flush(flush),
        .upd_we(upd_we), .upd_idx(upd_idx), .upd_data(upd_data),
        .mispredict(mispredict), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [1:0]       cnt;
    } entry_t;

    entry_t     model_q[$];
    logic [1:0] nxt_tbl [8];
    logic       exp_we;
    logic [9:0] exp_idx;
    logic [1:0] exp_data;
    logic       exp_mis;
    int         vectors = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".upd_we"}, 32'(upd_we), 32'(exp_we));
        check({tag, ".mispredict"}, 32'(mispredict), 32'(exp_mis));
        if (exp_we) begin
            check({tag, ".upd_idx"}, 32'(upd_idx), 32'(exp_idx));
            check({tag, ".upd_data"}, 32'(upd_data), 32'(exp_data));
        end
        check({tag, ".occupancy"}, 32'(occupancy), 32'(model_q.size()));
        check({tag, ".pred_ready"}, 32'(pred_ready), 32'(model_q.size() < DEPTH));
        check({tag, ".res_ready"}, 32'(res_ready), 32'(model_q.size() > 0));
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input string tag, input logic pv, input logic [IDX_W-1:0] pi,
                        input logic [1:0] pc, input logic rv, input logic rt, input logic fl);
        entry_t e;
        entry_t n;
        logic   do_push;
        logic   do_pop;
        pred_valid = pv;
        pred_idx   = pi;
        pred_cnt   = pc;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
        do_push = pv && (model_q.size() < DEPTH) && !fl;
        do_pop  = rv && (model_q.size() > 0);
        n.idx = pi;
        n.cnt = pc;
        exp_we  = 1'b0;
        exp_mis = 1'b0;
        if (do_pop) begin
            e = model_q.pop_front();
            exp_we   = 1'b1;
            exp_idx  = e.idx;
            exp_data = nxt_tbl[{e.cnt, rt}];
            exp_mis  = e.cnt[1] ^ rt;
`ifdef BHTQ_FWD_EN
            foreach (model_q[i]) begin
                if (model_q[i].idx == e.idx) model_q[i].cnt = exp_data;
            end
            if (pi == e.idx) n.cnt = exp_data;
`endif
        end
        if (fl) model_q.delete();
        if (do_push) model_q.push_back(n);
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        flush      = 1'b0;
        check_outputs(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        nxt_tbl = '{2'b01 & 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11};
        exp_we = 1'b0; exp_idx = '0; exp_data = '0; exp_mis = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.upd_idx", 32'(upd_idx), 32'h0);
        check("reset.upd_data", 32'(upd_data), 32'h0);
        check_outputs("reset");
        rst_n = 1'b1;

        // Single push then taken resolution of a strongly-not-taken counter.
        step("t1.push", 1'b1, 10'h0F0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("t1.pop", 1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
        check("t1.data_const", 32'(upd_data), 32'h1);
        check("t1.mis_const", 32'(mispredict), 32'h1);
        idle(1);

        // All eight counter/direction pairs.
        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 2; t++) begin
                step("t2.push", 1'b1, 10'h155, 2'(c), 1'b0, 1'b0, 1'b0);
                step("t2.pop", 1'b0, '0, 2'b00, 1'b1, 1'(t), 1'b0);
            end
        end
        idle(1);

        // Fill, overflow, drain.
        for (int i = 0; i < DEPTH + 1; i++) step("t3.fill", 1'b1, 10'(16 + i), 2'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step("t3.drain", 1'b0, '0, 2'b00, 1'b1, 1'(i & 1), 1'b0);
        step("t3.full_pp", 1'b1, 10'h3FF, 2'b10, 1'b1, 1'b1, 1'b0);

        // Flush concurrent with a pop, then a resolution against an empty queue.
        step("t4.push", 1'b1, 10'h021, 2'b11, 1'b0, 1'b0, 1'b0);
        step("t4.push", 1'b1, 10'h022, 2'b01, 1'b0, 1'b0, 1'b0);
        step("t4.flush", 1'b1, 10'h023, 2'b01, 1'b1, 1'b0, 1'b1);
        step("t4.empty_res", 1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);

        // Same-index back-to-back branches.
        for (int r = 0; r < 2; r++) begin
            step("t5.push", 1'b1, 10'h005, 2'b01, 1'b0, 1'b0, 1'b0);
            step("t5.push", 1'b1, 10'h005, 2'b01, 1'b0, 1'b0, 1'b0);
            step("t5.pop1", 1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
            check("t5.first_const", 32'(upd_data), 32'h3);
            step("t5.pop2", 1'b0, '0, 2'b00, 1'b1, (r == 0), 1'b0);
        end

        // Randomized traffic on a small index range so forwarding hits often.
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 60), 10'($urandom_range(0, 5)),
                 2'($urandom), 1'($urandom_range(0, 99) < 50), 1'($urandom),
                 1'($urandom_range(0, 99) < 4));
        end

        // Asynchronous reset with three entries queued and an update pulse live.
        idle(0);
        step("t6.flush", 1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step("t6.fill", 1'b1, 10'(32 + i), 2'b10, 1'b0, 1'b0, 1'b0);
        step("t6.pop", 1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
        check("t6.pre_occ", 32'(occupancy), 32'h3);
        check("t6.pre_we", 32'(upd_we), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        exp_we = 1'b0; exp_mis = 1'b0;
        check("t6.upd_idx", 32'(upd_idx), 32'h0);
        check("t6.upd_data", 32'(upd_data), 32'h0);
        check_outputs("t6.rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("t6.after", 1'b1, 10'h0AA, 2'b11, 1'b0, 1'b0, 1'b0);
        step("t6.after_pop", 1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
